// File: rtl/json_uart_pkg.sv
// json_uart_pkg: shared state type and defaults for the JSON UART transmitter
package json_uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_FIFO_DEPTH = 32;
    localparam logic UART_IDLE = 1'b1;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous FIFO with drop-on-full and a registered overflow pulse
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             overflow
);
    localparam int PW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic overflow_q, overflow_d;
    logic full, wr_en, rd_en;
    always_comb begin
        full       = count_q == CW'(DEPTH);
        empty      = count_q == '0;
        rd_en      = pop && !empty;
        wr_en      = push && (!full || rd_en);
        wr_ptr_d   = wr_ptr_q + PW'(wr_en);
        rd_ptr_d   = rd_ptr_q + PW'(rd_en);
        count_d    = count_q + CW'(wr_en) - CW'(rd_en);
        overflow_d = push && !wr_en;
        dout       = mem_q[rd_ptr_q[AW-1:0]];
        count      = count_q;
        overflow   = overflow_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/json_uart_tx.sv
// json_uart_tx: FIFO-buffered 8N1 UART transmitter for translator byte bursts
module json_uart_tx
    import json_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [7:0]                         ascii_in,
    input  logic                               in_valid,
    output logic                               tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               overflow
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    tx_state_t state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, head;
    logic tx_q, tx_d, pop, empty, baud_end;
    byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (in_valid),
        .pop      (pop),
        .din      (ascii_in),
        .dout     (head),
        .count    (fifo_count),
        .empty    (empty),
        .overflow (overflow)
    );
    always_comb begin
        baud_end = baud_q == BAUD_MAX;
        state_d  = state_q;
        baud_d   = baud_end ? '0 : baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = empty ? UART_IDLE : 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = START;
                end
            end
            START: if (baud_end) begin
                state_d = DATA;
                bit_d   = '0;
                tx_d    = shift_q[0];
            end
            DATA: if (baud_end) begin
                state_d = bit_q == 3'd7 ? STOP : DATA;
                bit_d   = bit_q + 3'd1;
                shift_d = shift_q >> 1;
                tx_d    = bit_q == 3'd7 ? UART_IDLE : shift_q[1];
            end
            STOP: if (baud_end) begin
                state_d = empty ? IDLE : START;
                tx_d    = empty ? UART_IDLE : 1'b0;
                pop     = !empty;
                shift_d = empty ? shift_q : head;
            end
            default: state_d = IDLE;
        endcase
        tx   = tx_q;
        busy = (state_q != IDLE) || !empty;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= UART_IDLE;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: tb/tb_json_uart_tx.sv
// tb_json_uart_tx: scoreboard bench decoding the UART line at 4 clocks per bit
module tb_json_uart_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] ascii_in = 8'h00;
    logic in_valid = 1'b0;
    logic tx, busy, overflow;
    logic [5:0] fifo_count;
    logic [7:0] sb [$];
    logic [7:0] mon_byte, exp_byte;
    int mon_cnt = -1;
    int n_cmp = 0;
    int n_err = 0;

    json_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ascii_in   (ascii_in),
        .in_valid   (in_valid),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Line decoder: sample mid-bit, pop the scoreboard at the middle of the stop bit
    always @(negedge clk) begin
        if (!rst_n) mon_cnt = -1;
        else if (mon_cnt < 0) begin
            if (tx === 1'b0) mon_cnt = 0;
        end else begin
            mon_cnt++;
            if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt - 6) % 4 == 0)
                mon_byte[(mon_cnt - 6) / 4] = tx;
            if (mon_cnt == 38) begin
                n_cmp++;
                if (tx !== 1'b1) begin
                    n_err++;
                    $display("FAIL stop_bit: got %b required 1", tx);
                end
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_byte: got %h required no transmission", mon_byte);
                end else begin
                    exp_byte = sb.pop_front();
                    if (mon_byte !== exp_byte) begin
                        n_err++;
                        $display("FAIL rx_byte: got %h required %h", mon_byte, exp_byte);
                    end
                end
                mon_cnt = -1;
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b required 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (fifo_count !== 6'd0) begin n_err++; $display("FAIL reset_count: got %0d required 0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        logic [9:0] f = {1'b1, 8'h7B, 1'b0};
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_cmp++; if (fifo_count !== 6'd1) begin n_err++; $display("FAIL single_count: got %0d required 1", fifo_count); end
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_rise: got %b required 1", busy); end
                n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL single_pre_start: got %b required 1", tx); end
            end
            if (c >= 2 && c < 42) begin
                n_cmp++;
                if (tx !== f[(c - 2) / 4]) begin n_err++; $display("FAIL single_tx cycle %0d: got %b required %b", c - 2, tx, f[(c - 2) / 4]); end
            end
            if (c == 41) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_hold: got %b required 1", busy); end
            end
            if (c == 42) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b required 0", busy); end
            end
            in_valid = (c == 0);
            ascii_in = 8'h7B;
            if (c == 0) sb.push_back(8'h7B);
        end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL single_drain: got %0d left required 0", sb.size()); end
    endtask

    task automatic test_back_to_back;
        logic [19:0] f = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (c >= 2 && c < 82) begin
                n_cmp++;
                if (tx !== f[(c - 2) / 4]) begin n_err++; $display("FAIL b2b_tx cycle %0d: got %b required %b", c - 2, tx, f[(c - 2) / 4]); end
            end
            if (c == 82) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_fall: got %b required 0", busy); end
            end
            in_valid = (c < 2);
            ascii_in = (c == 0) ? 8'h00 : 8'hFF;
            if (c < 2) sb.push_back(ascii_in);
        end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL b2b_drain: got %0d left required 0", sb.size()); end
    endtask

    task automatic test_frame;
        string s = "{\"T\":1,\"L\":0.50,\"R\":0.50}\r\n";
        int peak = 0, ovf = 0, start_c = -1, fall_c = -1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (overflow === 1'b1) ovf++;
            if (start_c < 0 && tx === 1'b0) start_c = c;
            if (start_c >= 0 && busy === 1'b0) begin fall_c = c; break; end
            in_valid = (c < s.len());
            if (c < s.len()) begin ascii_in = s[c]; sb.push_back(ascii_in); end
        end
        in_valid = 1'b0;
        n_cmp++; if (peak != 26) begin n_err++; $display("FAIL frame_peak: got %0d required 26", peak); end
        n_cmp++; if (ovf != 0) begin n_err++; $display("FAIL frame_overflow: got %0d required 0", ovf); end
        n_cmp++; if (fall_c - start_c != 1080) begin n_err++; $display("FAIL frame_span: got %0d required 1080", fall_c - start_c); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL frame_drain: got %0d left required 0", sb.size()); end
    endtask

    task automatic test_overflow;
        int ovf = 0;
        logic done = 1'b0;
        for (int c = 0; c < 1600; c++) begin
            @(negedge clk);
            if (overflow === 1'b1) ovf++;
            if (c == 33) begin
                n_cmp++; if (fifo_count !== 6'd32) begin n_err++; $display("FAIL ovf_full: got %0d required 32", fifo_count); end
            end
            if (c > 41 && busy === 1'b0) begin done = 1'b1; break; end
            in_valid = (c < 40);
            ascii_in = 8'(c * 7 + 3);
            if (c < 33) sb.push_back(ascii_in);
        end
        in_valid = 1'b0;
        n_cmp++; if (!done) begin n_err++; $display("FAIL ovf_timeout: got busy required idle"); end
        n_cmp++; if (ovf != 7) begin n_err++; $display("FAIL ovf_pulses: got %0d required 7", ovf); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL ovf_drain: got %0d left required 0", sb.size()); end
    endtask

    task automatic test_push_pop_full;
        int ovf = 0;
        logic done = 1'b0;
        for (int c = 0; c < 1600; c++) begin
            @(negedge clk);
            if (overflow === 1'b1) ovf++;
            if (c == 41 || c == 42) begin
                n_cmp++; if (fifo_count !== 6'd32) begin n_err++; $display("FAIL pp_count cycle %0d: got %0d required 32", c, fifo_count); end
            end
            if (c > 43 && busy === 1'b0) begin done = 1'b1; break; end
            in_valid = (c < 33 || c == 41);
            ascii_in = 8'(8'hC0 ^ c);
            if (in_valid) sb.push_back(ascii_in);
        end
        in_valid = 1'b0;
        n_cmp++; if (!done) begin n_err++; $display("FAIL pp_timeout: got busy required idle"); end
        n_cmp++; if (ovf != 0) begin n_err++; $display("FAIL pp_overflow: got %0d required 0", ovf); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL pp_drain: got %0d left required 0", sb.size()); end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 19) begin
                n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL mid_bit3: got %b required 0", tx); end
                break;
            end
            in_valid = (c < 6);
            ascii_in = 8'hA1 + 8'(c);
            if (c < 6) sb.push_back(ascii_in);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL mid_async_tx: got %b required 1", tx); end
        n_cmp++; if (fifo_count !== 6'd0) begin n_err++; $display("FAIL mid_count: got %0d required 0", fifo_count); end
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL mid_quiet: got %0d active cycles required 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame();
        test_overflow();
        test_push_pop_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/json_uart_tx.md
# json_uart_tx

Byte-stream UART transmitter sitting directly downstream of the command translator. It accepts the one-byte-per-clock ASCII JSON bursts that the translator emits, which are strobed by its `cmd_ready`. The bytes are absorbed into an internal FIFO and serialised as 8N1 UART frames on a single `tx` line to the motor controller. The FIFO decouples the translator's burst rate (one byte per clock) from the line rate.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Minimum 2.
- `FIFO_DEPTH`, 32: byte entries. Power of two, at least 27, so that one full JSON frame fits.
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `ascii_in` in 8: byte from the translator's `ascii_out`.
- `in_valid` in 1: byte strobe, driven by the translator's `cmd_ready`. One byte is written per cycle it is high.
- `tx` out 1: UART line, idle high.
- `busy` out 1: high while a frame is on the line or the FIFO is non-empty.
- `fifo_count` out `$clog2(FIFO_DEPTH+1)`: bytes currently queued.
- `overflow` out 1: one-cycle pulse for each byte dropped because the FIFO was full.

## Operation
- **Reset values:** `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0. FSM is in IDLE and the FIFO is emptied.
- **Write path:**
  - When `in_valid` is high and the FIFO is not full, the byte is written.
  - When `in_valid` is high and the FIFO is full with no pop that cycle, the byte is dropped and `overflow` pulses.
- **Simultaneous push and pop when full:** the push is accepted and `fifo_count` is unchanged.
- **Simultaneous push and pop when empty:** impossible, because a pop requires non-empty at the sampling edge.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START: taken when the FIFO is non-empty. The head byte is popped into the shift register on the same edge.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then → DATA.
  - DATA: 8 bits are sent LSB first, each for `CLKS_PER_BIT` cycles. A 3-bit counter tracks the bit; after bit 7 → STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end, go → START with a pop if the FIFO is non-empty, otherwise → IDLE.
  - There is no idle gap between back-to-back bytes.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1 and wraps. It is reset to 0 on every state entry.
- **Output register:** `tx` is registered, so there are no glitches.
- **No frame awareness:** bytes are transmitted exactly in arrival order. A dropped byte corrupts the JSON frame; recovery is the receiver's job. `overflow` is provided for debug or an LED.
- **Reset mid-frame:** `tx` goes to 1 immediately (asynchronous) and queued bytes are lost.

## Timing
- **Write latency:** a byte sampled at edge k appears in `fifo_count` after edge k.
- **Start latency from idle:** at edge k+1 the FSM pops the byte, and `tx` falls after edge k+1. The start bit therefore begins 2 edges after the write.
- **Frame length:** 10×`CLKS_PER_BIT` cycles per byte. A 27-byte JSON frame occupies 270×`CLKS_PER_BIT` cycles.
- **`busy`:** rises after edge k (the write). It falls after the final STOP cycle, but only if the FIFO is empty at that point.
- **`overflow`:** asserted in the cycle after the edge that drops the byte, for exactly one cycle per drop.

## Structure
- **Package `json_uart_pkg`:** `tx_state_t` enum (IDLE, START, DATA, STOP), default `CLKS_PER_BIT`/`FIFO_DEPTH` localparams, and `UART_IDLE`=1'b1.
- **Sub-module `byte_fifo`:** synchronous FIFO, parameterised by width and depth. It has registered read/write pointers (one extra wrap bit), count, full/empty, and drop-on-full. The top level holds the FSM, baud counter, bit counter, and shift register.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=32.
- **Single byte:** write 0x7B ('{') once from reset. Required: `tx` = 0,1,1,0,1,1,1,1,0,1, each held 4 cycles. Start bit begins 2 edges after the write, and `busy` falls 40 cycles after the start bit.
- **Full frame:** drive the 27-byte frame `{"T":1,"L":0.50,"R":0.50}` at one byte per clock. Required: peak `fifo_count`=26, no `overflow`, and the decoded line output equals the string in order. The line is continuous for 1080 cycles with no gaps.
- **Overflow:** drive 40 consecutive writes from idle. Required:
  - `fifo_count` reaches 32 after the 33rd edge.
  - Exactly 7 `overflow` pulses.
  - 33 bytes transmitted, namely the first 33 written.
- **Back-to-back:** write 0x00 then 0xFF on consecutive cycles. Required: the stop bit of byte 1 lasts exactly 4 cycles and is followed immediately by the start bit of byte 2.
- **Reset mid-byte:** assert `rst_n`=0 during DATA bit 3 of a byte with 5 more queued. Required: `tx`=1 asynchronously and `fifo_count`=0. After release, the line stays idle with no further transmission.
- **Push/pop when full:** fill to 32, then push in the exact cycle a STOP ends. Required: the byte is accepted, there is no `overflow`, and `fifo_count` stays at 32.
